// File: rtl/tri_lcb_seq_pkg.sv
// Shared definitions for the LCB clock-control sequencer: state encoding
// and a counter-width helper for the group and stagger counters.
package tri_lcb_seq_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED    = 3'd0,
        ST_START      = 3'd1,
        ST_RUN        = 3'd2,
        ST_STOP       = 3'd3,
        ST_SCAN_SETUP = 3'd4,
        ST_SCAN       = 3'd5,
        ST_SCAN_EXIT  = 3'd6
    } seq_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tri_lcb_seq_pipe.sv
// Depth-configurable register chain used to carry latch controls to distant
// latch groups; each bit resets to its own value from RST_VAL.
module tri_lcb_seq_pipe #(
    parameter int            W       = 1,
    parameter int            DEPTH   = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_b_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [W-1:0] stage_q [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk_i or negedge rst_b_i) begin
                        if (!rst_b_i) stage_q[gi] <= RST_VAL;
                        else          stage_q[gi] <= d_i;
                    end
                end else begin : g_body
                    always_ff @(posedge clk_i or negedge rst_b_i) begin
                        if (!rst_b_i) stage_q[gi] <= RST_VAL;
                        else          stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tri_lcb_seq.sv
// Clock-control sequencer for LCB-included latches: staggered thold_b release
// and hold, scan sg/force_t bracketing, and request error reporting.
module tri_lcb_seq
    import tri_lcb_seq_pkg::*;
#(
    parameter int NUM_GRP        = 4,
    parameter int STAGGER        = 2,
    parameter int PIPE           = 1,
    parameter int START_ON_RESET = 0
) (
    input  logic               nclk,
    input  logic               rst_b,
    input  logic               start_req,
    input  logic               stop_req,
    input  logic               scan_req,
    input  logic               scan_done,
    output logic [NUM_GRP-1:0] thold_b,
    output logic               sg,
    output logic               force_t,
    output logic               running,
    output logic               stopped,
    output logic               err
);

    localparam int GRP_W  = cnt_w(NUM_GRP);
    localparam int STAG_W = cnt_w(STAGGER);
    localparam int PIPE_W = NUM_GRP + 4;

    localparam logic [GRP_W-1:0]   LAST_GRP  = GRP_W'(NUM_GRP - 1);
    localparam logic [STAG_W-1:0]  STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [NUM_GRP-1:0] GRP0_ONLY = NUM_GRP'(1);
    localparam logic [PIPE_W-1:0]  PIPE_RST  = PIPE_W'(1);

    seq_state_e          state_q, state_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [STAG_W-1:0]   stag_q, stag_d;
    logic [NUM_GRP-1:0]  thold_q, thold_d;
    logic                sg_q, sg_d;
    logic                force_q, force_d;
    logic                run_q, run_d;
    logic                stop_q, stop_d;
    logic                err_q, err_d;
    logic                first_q;

    logic                start_eff;
    logic                stag_tick;
    logic [GRP_W-1:0]    grp_inc;

    // The first post-reset edge can stand in for a start request.
    assign start_eff = start_req | ((START_ON_RESET != 0) & first_q);
    assign stag_tick = (stag_q == STAG_LAST);
    assign grp_inc   = grp_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        stag_d  = stag_q;
        thold_d = thold_q;
        sg_d    = sg_q;
        force_d = force_q;
        run_d   = run_q;
        stop_d  = stop_q;
        err_d   = 1'b0;

        case (state_q)
            ST_STOPPED: begin
                err_d = scan_req & start_eff;
                if (scan_req) begin
                    state_d = ST_SCAN_SETUP;
                    sg_d    = 1'b1;
                    stop_d  = 1'b0;
                end else if (start_eff) begin
                    thold_d = GRP0_ONLY;
                    stop_d  = 1'b0;
                    grp_d   = '0;
                    stag_d  = '0;
                    if (NUM_GRP == 1) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end

            ST_START, ST_RUN: begin
                err_d = scan_req;
                // grp_q is the highest released group; hold it now, then descend.
                if (stop_req) begin
                    run_d   = 1'b0;
                    thold_d = thold_q >> 1;
                    stag_d  = '0;
                    if (grp_q == '0) begin
                        state_d = ST_STOPPED;
                        stop_d  = 1'b1;
                    end else begin
                        state_d = ST_STOP;
                        grp_d   = grp_q - 1'b1;
                    end
                end else if (state_q == ST_START) begin
                    stag_d = stag_q + 1'b1;
                    if (stag_tick) begin
                        stag_d  = '0;
                        thold_d = (thold_q << 1) | GRP0_ONLY;
                        grp_d   = grp_inc;
                        if (grp_inc == LAST_GRP) begin
                            state_d = ST_RUN;
                            run_d   = 1'b1;
                        end
                    end
                end
            end

            ST_STOP: begin
                err_d  = scan_req | start_eff;
                stag_d = stag_q + 1'b1;
                if (stag_tick) begin
                    stag_d  = '0;
                    thold_d = thold_q >> 1;
                    if (grp_q == '0) begin
                        state_d = ST_STOPPED;
                        stop_d  = 1'b1;
                    end else begin
                        grp_d = grp_q - 1'b1;
                    end
                end
            end

            ST_SCAN_SETUP: begin
                err_d   = scan_req | start_eff | stop_req;
                force_d = 1'b1;
                state_d = ST_SCAN;
            end

            ST_SCAN: begin
                err_d = scan_req | start_eff | stop_req;
                if (scan_done) begin
                    force_d = 1'b0;
                    state_d = ST_SCAN_EXIT;
                end
            end

            ST_SCAN_EXIT: begin
                err_d   = scan_req | start_eff | stop_req;
                sg_d    = 1'b0;
                stop_d  = 1'b1;
                state_d = ST_STOPPED;
            end

            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_STOPPED;
            grp_q   <= '0;
            stag_q  <= '0;
            thold_q <= '0;
            sg_q    <= 1'b0;
            force_q <= 1'b0;
            run_q   <= 1'b0;
            stop_q  <= 1'b1;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            stag_q  <= stag_d;
            thold_q <= thold_d;
            sg_q    <= sg_d;
            force_q <= force_d;
            run_q   <= run_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            first_q <= 1'b0;
        end
    end

    // err stays unpiped so it always lands the cycle after the offending sample.
    tri_lcb_seq_pipe #(
        .W       (PIPE_W),
        .DEPTH   (PIPE),
        .RST_VAL (PIPE_RST)
    ) u_pipe (
        .clk_i   (nclk),
        .rst_b_i (rst_b),
        .d_i     ({thold_q, sg_q, force_q, run_q, stop_q}),
        .q_o     ({thold_b, sg, force_t, running, stopped})
    );

    assign err = err_q;

endmodule

// File: tb/tb_tri_lcb_seq.sv
// Directed bench for tri_lcb_seq: vector table plus hand-written multi-cycle
// sequences, with a second instance built with START_ON_RESET=1.
module tb_tri_lcb_seq;

    logic       nclk = 1'b0;
    logic       rst_b, start_req, stop_req, scan_req, scan_done;
    logic [3:0] thold_b;
    logic       sg, force_t, running, stopped, err;

    logic       rst_b2, idle_start, idle_stop, idle_scan, idle_done;
    logic [3:0] thold_b2;
    logic       sg2, force_t2, running2, stopped2, err2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       scan;
        logic       done;
        logic [8:0] exp;
    } vec_t;

    vec_t       vq[$];
    logic [8:0] sor_tab [8];

    always #5 nclk = ~nclk;

    tri_lcb_seq #(.NUM_GRP(4), .STAGGER(2), .PIPE(1), .START_ON_RESET(0)) dut (
        .nclk      (nclk),
        .rst_b     (rst_b),
        .start_req (start_req),
        .stop_req  (stop_req),
        .scan_req  (scan_req),
        .scan_done (scan_done),
        .thold_b   (thold_b),
        .sg        (sg),
        .force_t   (force_t),
        .running   (running),
        .stopped   (stopped),
        .err       (err)
    );

    tri_lcb_seq #(.NUM_GRP(4), .STAGGER(2), .PIPE(1), .START_ON_RESET(1)) dut_sor (
        .nclk      (nclk),
        .rst_b     (rst_b2),
        .start_req (idle_start),
        .stop_req  (idle_stop),
        .scan_req  (idle_scan),
        .scan_done (idle_done),
        .thold_b   (thold_b2),
        .sg        (sg2),
        .force_t   (force_t2),
        .running   (running2),
        .stopped   (stopped2),
        .err       (err2)
    );

    function automatic logic [8:0] mk(input logic [3:0] th, input logic g, input logic f,
                                      input logic r, input logic s, input logic e);
        return {th, g, f, r, s, e};
    endfunction

    function automatic logic [8:0] obs();
        return {thold_b, sg, force_t, running, stopped, err};
    endfunction

    function automatic logic [8:0] obs2();
        return {thold_b2, sg2, force_t2, running2, stopped2, err2};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got thold/sg/force/run/stop/err=%b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic sc, input logic dn,
                       input logic [3:0] th, input logic g, input logic f,
                       input logic r, input logic s, input logic e);
        vec_t v;
        v.start = st; v.stop = sp; v.scan = sc; v.done = dn;
        v.exp   = mk(th, g, f, r, s, e);
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, input logic sp, input logic sc, input logic dn);
        start_req = st; stop_req = sp; scan_req = sc; scan_done = dn;
    endtask

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Edge n applies the row's inputs; expectation is observed just after edge n.
        //   st sp sc dn   thold    sg f  run stp err
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0);  // e0 start accepted
        add(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);  // e1
        add(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);  // e2
        add(0, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0);  // e3
        add(0, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0);  // e4
        add(0, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 0);  // e5
        add(0, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 0);  // e6
        add(0, 0, 0, 0, 4'b1111, 0, 0, 1, 0, 0);  // e7 running
        add(0, 0, 1, 0, 4'b1111, 0, 0, 1, 0, 1);  // e8 scan in RUN -> err
        add(0, 0, 0, 0, 4'b1111, 0, 0, 1, 0, 0);  // e9 err one cycle only
        add(1, 1, 0, 0, 4'b1111, 0, 0, 1, 0, 0);  // e10 start+stop -> stop, no err
        add(0, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 0);  // e11
        add(1, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 1);  // e12 start during STOP -> err
        add(0, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0);  // e13
        add(0, 1, 0, 0, 4'b0011, 0, 0, 0, 0, 0);  // e14 stop in STOP idempotent
        add(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);  // e15
        add(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);  // e16
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0);  // e17 stopped
        add(1, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);  // e18 scan+start -> scan, err
        add(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0);  // e19 sg
        add(0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 0);  // e20 force_t
        add(0, 1, 0, 0, 4'b0000, 1, 1, 0, 0, 1);  // e21 stop during scan -> err
        add(0, 0, 0, 1, 4'b0000, 1, 1, 0, 0, 0);  // e22 scan_done
        add(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0);  // e23 force_t drops
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0);  // e24 sg drops, stopped
        add(0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 0);  // e25 scan_done ignored
        add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 0);  // e26 stop in STOPPED idempotent

        sor_tab[0] = mk(4'b0000, 0, 0, 0, 1, 0);
        sor_tab[1] = mk(4'b0001, 0, 0, 0, 0, 0);
        sor_tab[2] = mk(4'b0001, 0, 0, 0, 0, 0);
        sor_tab[3] = mk(4'b0011, 0, 0, 0, 0, 0);
        sor_tab[4] = mk(4'b0011, 0, 0, 0, 0, 0);
        sor_tab[5] = mk(4'b0111, 0, 0, 0, 0, 0);
        sor_tab[6] = mk(4'b0111, 0, 0, 0, 0, 0);
        sor_tab[7] = mk(4'b1111, 0, 0, 1, 0, 0);

        rst_b = 1'b0; rst_b2 = 1'b0;
        drive(0, 0, 0, 0);
        idle_start = 1'b0; idle_stop = 1'b0; idle_scan = 1'b0; idle_done = 1'b0;
        repeat (3) tick();
        check("reset_defaults", obs(), mk(4'b0000, 0, 0, 0, 1, 0));
        check("reset_defaults_sor", obs2(), mk(4'b0000, 0, 0, 0, 1, 0));

        rst_b = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].start, vq[i].stop, vq[i].scan, vq[i].done);
            tick();
            check($sformatf("vec_e%0d", i), obs(), vq[i].exp);
        end
        drive(0, 0, 0, 0);

        // Stop during START with groups 0,1 released.
        drive(1, 0, 0, 0); tick(); check("abort_e0", obs(), mk(4'b0000, 0, 0, 0, 1, 0));
        drive(0, 0, 0, 0); tick(); check("abort_e1", obs(), mk(4'b0001, 0, 0, 0, 0, 0));
        tick();                    check("abort_e2", obs(), mk(4'b0001, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0); tick(); check("abort_e3", obs(), mk(4'b0011, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0); tick(); check("abort_e4", obs(), mk(4'b0001, 0, 0, 0, 0, 0));
        tick();                    check("abort_e5", obs(), mk(4'b0001, 0, 0, 0, 0, 0));
        tick();                    check("abort_e6", obs(), mk(4'b0000, 0, 0, 0, 1, 0));

        // Asynchronous reset mid-START at thold_b=0011.
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0); tick(); tick(); tick();
        check("midstart_pre_reset", obs(), mk(4'b0011, 0, 0, 0, 0, 0));
        #2 rst_b = 1'b0;
        #1 check("midstart_async_reset", obs(), mk(4'b0000, 0, 0, 0, 1, 0));
        tick(); tick();
        rst_b = 1'b1;
        tick(); tick();
        check("midstart_after_release", obs(), mk(4'b0000, 0, 0, 0, 1, 0));

        // START_ON_RESET instance: the first edge after release acts as start.
        rst_b2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("sor_e%0d", k), obs2(), sor_tab[k]);
        end
        #2 rst_b2 = 1'b0;
        #1 check("sor_async_reset_run", obs2(), mk(4'b0000, 0, 0, 0, 1, 0));
        tick();
        rst_b2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("sor2_e%0d", k), obs2(), sor_tab[k]);
        end
        #2 rst_b2 = 1'b0;
        #1 check("sor_async_reset_start", obs2(), mk(4'b0000, 0, 0, 0, 1, 0));
        tick();
        rst_b2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("sor3_e%0d", k), obs2(), sor_tab[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tri_lcb_seq.md
Name: tri_lcb_seq

Overview:
Clock-control sequencer that sits directly upstream of the trilib LCB-included latches. It generates the per-group thold_b, sg and force_t controls those latches consume.
- Releases thold_b group-by-group on start and re-asserts hold in reverse order on stop, limiting di/dt.
- Brackets scan operations with sg/force_t while clocks are held.
- Output controls are staged through plat-style pipeline registers to reach distant latch groups.

Parameters:
NUM_GRP, 4, number of thold_b groups (1..16)
STAGGER, 2, cycles between successive group release/hold (1..15)
PIPE, 1, output pipeline stages on thold_b/sg/force_t/running/stopped (0..3)
START_ON_RESET, 0, 1: first edge after reset deassertion behaves as an accepted start_req

Ports:
nclk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
start_req  in  1  request clocks running (level, sampled each edge)
stop_req  in  1  request clocks held
scan_req  in  1  request scan window
scan_done  in  1  scan shifting complete
thold_b  out  NUM_GRP  per-group thold, bit 0 = group 0; 1 = functional
sg  out  1  scan gate to latches
force_t  out  1  force LCB active during scan
running  out  1  all groups released
stopped  out  1  all groups held, no scan active
err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (rst_b=0, asynchronous, including all pipe stages):
  - thold_b=0, sg=0, force_t=0, running=0, stopped=1, err=0
  - state STOPPED, counters 0.
- States: STOPPED, START, RUN, STOP, SCAN_SETUP, SCAN, SCAN_EXIT.
- Internal registers: thold_int, sg_int, force_int, run_int, stop_int. Outputs are these delayed by PIPE extra registers. err is never piped: asserted the cycle after the offending sample.
- STOPPED + start_req at edge t:
  - Group k is released in thold_int at edge t+k*STAGGER.
  - State becomes RUN, with run_int=1, on the edge group NUM_GRP-1 is released.
  - stop_int clears at edge t.
- RUN + stop_req at edge s:
  - run_int clears at s.
  - Group NUM_GRP-1 is held at s; each next-lower group is held every STAGGER cycles.
  - STOPPED, with stop_int=1, is entered on the edge group 0 is held.
- START + stop_req, groups 0..g released: the highest released group g is held at that edge, then groups descend as in STOP.
- STOPPED + scan_req at edge e:
  - SCAN_SETUP, sg_int=1, stop_int=0 at e.
  - force_int=1, SCAN at e+1.
  - scan_done sampled in SCAN: force_int=0, SCAN_EXIT.
  - Next edge: sg_int=0, stop_int=1, STOPPED.
  - thold_int stays all-0 throughout.
- Priority within one sample: stop_req > scan_req > start_req.
  - start+stop in RUN/START: stop taken, no err.
  - scan+start in STOPPED: scan taken, err pulse.
- Idempotent requests, ignored without err: start_req in START/RUN; stop_req in STOP/STOPPED.
- Every other non-accepted request pulses err for 1 cycle and is ignored. Examples: scan_req outside STOPPED; start_req during STOP/scan states; stop_req during scan states.
- scan_done outside SCAN is ignored.
- NUM_GRP=1: START→RUN on the accepting edge; STOP→STOPPED on the accepting edge.
- Reset mid-sequence:
  - Immediate return to reset values; no partial-release outputs survive.
  - START_ON_RESET=1: start is accepted on the first edge with rst_b=1.

Decomposition:
- Shared include: state encodings, and localparam widths for the group and STAGGER counters (clog2 helpers).
- One sub-module, tri_lcb_seq_pipe: a parameterized-width, depth-PIPE register chain with async active-low reset and a per-bit reset value vector. It is instantiated once over {thold, sg, force, running, stopped}.

Test Plan:
1. Defaults; reset release; start_req pulse at edge 0 → thold_b 0001b→0011b→0111b→1111b (group 0 = rightmost digit) after edges 1,3,5,7; running=1 after edge 7; stopped=0 after edge 1.
2. From RUN, stop_req at edge 20 → running=0 and thold_b 0111b after edge 21; 0011b@23, 0001b@25, 0000b@27; stopped=1 after edge 27.
3. Start at edge 0, stop_req at edge 3 (groups 0,1 released) → thold_b 0001b after edge 4, 0000b after edge 6, stopped=1 after edge 6, no err.
4. STOPPED, scan_req edge 0 → sg=1 after edge 1, force_t=1 after edge 2. scan_done at edge 10 → force_t=0 after edge 11, sg=0 and stopped=1 after edge 12; thold_b=0 throughout.
5. Illegal and simultaneous requests:
   - scan_req in RUN → err=1 exactly one cycle, outputs unchanged.
   - start+stop together in RUN → stop sequence, err=0.
   - scan+start in STOPPED → scan path, err pulse.
6. rst_b low mid-START (thold_b=0011b) → all outputs reset asynchronously before the next edge. With START_ON_RESET=1, release reproduces the scenario 1 timing from the first edge.
